// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - round-robin arbiter sharing the VGA write port between three box requesters
module draw_scheduler #(
  parameter int         BOX_W     = 4,
  parameter int         BOX_H     = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [2:0]  req_erase,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  typedef enum logic [1:0] {IDLE, LOAD, PLOT, DONE} state_t;

  localparam logic [3:0] LAST_X = 4'(BOX_W - 1);
  localparam logic [3:0] LAST_Y = 4'(BOX_H - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] job_colour;
  logic [3:0] cx;
  logic [3:0] cy;

  logic [1:0] p0, p1, p2, pick;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_colour;
  logic       sel_erase;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search order starts at ptr so the last-served requester goes to the back.
  always_comb begin
    p0   = ptr;
    p1   = inc3(p0);
    p2   = inc3(p1);
    pick = req[p0] ? p0 : (req[p1] ? p1 : p2);
  end

  always_comb begin
    sel_x      = req_x[7:0];
    sel_y      = req_y[6:0];
    sel_colour = req_colour[2:0];
    sel_erase  = req_erase[0];
    case (winner)
      2'd1: begin
        sel_x      = req_x[15:8];
        sel_y      = req_y[13:7];
        sel_colour = req_colour[5:3];
        sel_erase  = req_erase[1];
      end
      2'd2: begin
        sel_x      = req_x[23:16];
        sel_y      = req_y[20:14];
        sel_colour = req_colour[8:6];
        sel_erase  = req_erase[2];
      end
      default: ;
    endcase
  end

  assign sum_x = {1'b0, base_x} + {5'd0, cx};
  assign sum_y = {1'b0, base_y} + {4'd0, cy};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      winner     <= 2'd0;
      grant      <= 3'b000;
      done       <= 3'b000;
      busy       <= 1'b0;
      base_x     <= 8'd0;
      base_y     <= 7'd0;
      job_colour <= 3'b000;
      cx         <= 4'd0;
      cy         <= 4'd0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'b000;
      vga_plot   <= 1'b0;
    end else begin
      done     <= 3'b000;
      vga_plot <= 1'b0;
      case (state)
        IDLE: begin
          grant <= 3'b000;
          if (|req) begin
            winner <= pick;
            grant  <= 3'b001 << pick;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          base_x     <= sel_x;
          base_y     <= sel_y;
          job_colour <= sel_erase ? BG_COLOUR : sel_colour;
          cx         <= 4'd0;
          cy         <= 4'd0;
          state      <= PLOT;
        end
        PLOT: begin
          // Off-screen pixels still take their cycle so job length stays fixed.
          vga_x      <= sum_x[7:0];
          vga_y      <= sum_y[6:0];
          vga_colour <= job_colour;
          vga_plot   <= (sum_x <= 9'd159) && (sum_y <= 8'd119);
          if (cx == LAST_X) begin
            cx <= 4'd0;
            if (cy == LAST_Y) begin
              state <= DONE;
            end else begin
              cy <= cy + 4'd1;
            end
          end else begin
            cx <= cx + 4'd1;
          end
        end
        DONE: begin
          done  <= 3'b001 << winner;
          ptr   <= inc3(winner);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - scoreboard bench for draw_scheduler
module tb_draw_scheduler;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req;
  logic [2:0]  req_erase;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] exp_q[$];

  draw_scheduler dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_erase(req_erase),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .grant(grant), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vga_plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pix_extra", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
      end else begin
        check("pix", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_box(input int x, input int y, input logic [2:0] col);
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        int sx, sy;
        sx = x + i;
        sy = y + j;
        if (sx <= 159 && sy <= 119) exp_q.push_back({8'(sx), 7'(sy), col});
      end
    end
  endtask

  task automatic set_req_data(input int r, input int x, input int y, input logic [2:0] col, input logic er);
    req_x[8*r +: 8]      = 8'(x);
    req_y[7*r +: 7]      = 7'(y);
    req_colour[3*r +: 3] = col;
    req_erase[r]         = er;
  endtask

  task automatic wait_done(output int n, output logic [2:0] d, output logic [2:0] g1, output logic b1);
    n = 0; d = 3'b000; g1 = 3'b000; b1 = 1'b0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        g1 = grant;
        b1 = busy;
      end
      if (done != 3'b000) begin
        d = done;
        break;
      end
    end
  endtask

  task automatic finish_job(input string tag);
    req = 3'b000;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_1cyc"}, {29'd0, done}, 32'd0);
    check({tag, "_q_empty"}, exp_q.size(), 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic single_job(input string tag, input int r, input int x, input int y,
                            input logic [2:0] col, input logic er);
    int n;
    logic [2:0] d, g1;
    logic b1;
    set_req_data(r, x, y, col, er);
    push_box(x, y, er ? 3'b000 : col);
    req = 3'b001 << r;
    wait_done(n, d, g1, b1);
    check({tag, "_cycles"}, n, N + 3);
    check({tag, "_done"}, {29'd0, d}, {29'd0, 3'b001 << r});
    check({tag, "_grant"}, {29'd0, g1}, {29'd0, 3'b001 << r});
    check({tag, "_busy"}, {31'd0, b1}, 32'd1);
    check({tag, "_grant_at_done"}, {29'd0, grant}, {29'd0, 3'b001 << r});
    finish_job(tag);
  endtask

  initial begin
    int n;
    logic [2:0] d, g1;
    logic b1;
    int order[4];

    reset_n = 1'b0; req = 3'b000; req_erase = 3'b000;
    req_x = 24'd0; req_y = 21'd0; req_colour = 9'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_grant", {29'd0, grant}, 32'd0);
    check("rst_done", {29'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_vga", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    check("rst_plot", {31'd0, vga_plot}, 32'd0);

    single_job("draw", 0, 10, 20, 3'b100, 1'b0);
    single_job("erase", 1, 30, 40, 3'b111, 1'b1);
    single_job("clip", 2, 158, 118, 3'b011, 1'b0);

    // ptr is back at 0: full contention should rotate 0,1,2,0
    set_req_data(0, 10, 20, 3'b100, 1'b0);
    set_req_data(1, 30, 40, 3'b111, 1'b1);
    set_req_data(2, 70, 80, 3'b010, 1'b0);
    order = '{0, 1, 2, 0};
    push_box(10, 20, 3'b100);
    push_box(30, 40, 3'b000);
    push_box(70, 80, 3'b010);
    push_box(10, 20, 3'b100);
    req = 3'b111;
    for (int j = 0; j < 4; j++) begin
      wait_done(n, d, g1, b1);
      if (j == 3) req = 3'b000;
      check($sformatf("cont%0d_grant", j), {29'd0, g1}, {29'd0, 3'b001 << order[j]});
      check($sformatf("cont%0d_cycles", j), n, N + 3);
      check($sformatf("cont%0d_done", j), {29'd0, d}, {29'd0, 3'b001 << order[j]});
    end
    @(posedge clk);
    @(negedge clk);
    check("cont_q_empty", exp_q.size(), 32'd0);

    // ptr is 1: requester 1 alone, then disturb its inputs mid-job
    set_req_data(1, 50, 60, 3'b011, 1'b0);
    push_box(50, 60, 3'b011);
    req = 3'b010;
    repeat (5) @(posedge clk);
    @(negedge clk);
    req = 3'b000;
    req_x[15:8] = 8'd99;
    req_colour[5:3] = 3'b110;
    wait_done(n, d, g1, b1);
    check("mid_cycles", n, N + 3 - 5);
    check("mid_done", {29'd0, d}, 32'd2);
    finish_job("mid");

    // ptr is 2: start requester 2, then reset during PLOT
    set_req_data(2, 0, 0, 3'b101, 1'b0);
    push_box(0, 0, 3'b101);
    req = 3'b100;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("mrst_grant", {29'd0, grant}, 32'd0);
    check("mrst_done", {29'd0, done}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_vga", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    check("mrst_plot", {31'd0, vga_plot}, 32'd0);
    exp_q.delete();
    set_req_data(0, 5, 5, 3'b001, 1'b0);
    set_req_data(1, 20, 20, 3'b010, 1'b0);
    set_req_data(2, 40, 40, 3'b100, 1'b0);
    push_box(5, 5, 3'b001);
    req = 3'b111;
    wait_done(n, d, g1, b1);
    check("mrst_win_grant", {29'd0, g1}, 32'd1);
    check("mrst_win_cycles", n, N + 3);
    check("mrst_win_done", {29'd0, d}, 32'd1);
    finish_job("mrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
